// File: rtl/crash_event_ctrl_pkg.sv
// Shared game status codes, BCD widths and FSM state types
// for the frame-level crash event controller.
package crash_event_ctrl_pkg;

    localparam int GAME_STATUS_BIT_LEN = 3;
    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_DIGITS = 4;

    localparam logic [GAME_STATUS_BIT_LEN-1:0] ST_PAUSE  = 3'b000;
    localparam logic [GAME_STATUS_BIT_LEN-1:0] ST_RUN    = 3'b001;
    localparam logic [GAME_STATUS_BIT_LEN-1:0] ST_PRERUN = 3'b010;
    localparam logic [GAME_STATUS_BIT_LEN-1:0] ST_OVER   = 3'b011;

    typedef enum logic {
        EN_IDLE,
        EN_EXPLODE
    } enemy_st_e;

    typedef enum logic [1:0] {
        PL_ALIVE,
        PL_INVULN,
        PL_DEAD
    } player_st_e;

endpackage

// File: rtl/crash_event_ctrl_if.sv
// Bundle between the game controller, renderers and the
// crash event controller.
interface crash_event_ctrl_if;
    import crash_event_ctrl_pkg::*;

    logic [GAME_STATUS_BIT_LEN-1:0] game_status_i;
    logic                           frame_end_i;
    logic                           crash_enemy_bullet_i;
    logic                           crash_me_enemy_i;
    logic                           enemy_hit_o;
    logic                           me_hit_o;
    logic                           explode_o;
    logic [1:0]                     explode_step_o;
    logic                           invuln_o;
    logic [15:0]                    score_o;
    logic [1:0]                     lives_o;
    logic                           gameover_req_o;

    modport master (
        output game_status_i, frame_end_i,
        output crash_enemy_bullet_i, crash_me_enemy_i,
        input  enemy_hit_o, me_hit_o, explode_o, explode_step_o,
        input  invuln_o, score_o, lives_o, gameover_req_o
    );

    modport slave (
        input  game_status_i, frame_end_i,
        input  crash_enemy_bullet_i, crash_me_enemy_i,
        output enemy_hit_o, me_hit_o, explode_o, explode_step_o,
        output invuln_o, score_o, lives_o, gameover_req_o
    );

endinterface

// File: rtl/crash_event_ctrl_bcd_counter4.sv
// Four-digit BCD incrementer that sticks at 9999 instead of
// wrapping; sync clear has priority over increment.
module bcd_counter4
    import crash_event_ctrl_pkg::*;
(
    input  logic                              clk_vga,
    input  logic                              rst_n,
    input  logic                              clr,
    input  logic                              inc,
    output logic [BCD_DIGITS*BCD_DIGIT_W-1:0] count
);

    logic [BCD_DIGITS*BCD_DIGIT_W-1:0] nxt;
    logic [BCD_DIGIT_W-1:0]            dig;
    logic                              carry;

    // Ripple a +1 through the digits; carry out means all nines
    always_comb begin
        nxt   = count;
        dig   = '0;
        carry = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            dig = count[i*BCD_DIGIT_W +: BCD_DIGIT_W];
            if (carry) begin
                if (dig == 4'd9) begin
                    nxt[i*BCD_DIGIT_W +: BCD_DIGIT_W] = '0;
                end else begin
                    nxt[i*BCD_DIGIT_W +: BCD_DIGIT_W] = dig + 1'b1;
                    carry = 1'b0;
                end
            end
        end
    end

    // Hold at 9999 when the ripple would overflow
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !carry) begin
            count <= nxt;
        end
    end

endmodule

// File: rtl/crash_event_ctrl.sv
// Collapses per-pixel crash flags into one event per frame and
// runs explosion, score, lives and invulnerability state.
module crash_event_ctrl
    import crash_event_ctrl_pkg::*;
#(
    parameter int LIVES_INIT      = 3,
    parameter int EXPLODE_STEPS   = 4,
    parameter int FRAMES_PER_STEP = 4,
    parameter int INVULN_FRAMES   = 60
) (
    input  logic               clk_vga,
    input  logic               rst_n,
    crash_event_ctrl_if.slave  bus
);

    localparam logic [1:0] LIVES_RST = 2'(LIVES_INIT);
    localparam logic [1:0] STEP_LAST = 2'(EXPLODE_STEPS - 1);
    localparam logic [3:0] FRM_LAST  = 4'(FRAMES_PER_STEP - 1);
    localparam logic [5:0] INV_LAST  = 6'(INVULN_FRAMES - 1);

    logic [GAME_STATUS_BIT_LEN-1:0] prev_status;
    logic       run, start, eval;
    logic       eb_seen, me_seen, hit_eb, hit_me;
    enemy_st_e  en_st;
    player_st_e pl_st;
    logic [3:0] fcnt;
    logic [1:0] step;
    logic [5:0] icnt;
    logic [1:0] lives;
    logic       enemy_hit, me_hit, explode, invuln, gameover;
    logic       score_inc;

    assign run    = bus.game_status_i == ST_RUN;
    assign start  = run && (prev_status == ST_PRERUN);
    assign eval   = run && bus.frame_end_i && !start;
    assign hit_eb = eb_seen | bus.crash_enemy_bullet_i;
    assign hit_me = me_seen | bus.crash_me_enemy_i;

    assign score_inc = eval && (en_st == EN_IDLE) && hit_eb;

    // Remember last cycle's status to catch the game start edge
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) prev_status <= ST_PAUSE;
        else        prev_status <= bus.game_status_i;
    end

    // Sticky per-frame crash flags, only live while running
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            eb_seen <= 1'b0;
            me_seen <= 1'b0;
        end else if (!run || bus.frame_end_i) begin
            eb_seen <= 1'b0;
            me_seen <= 1'b0;
        end else begin
            if (bus.crash_enemy_bullet_i) eb_seen <= 1'b1;
            if (bus.crash_me_enemy_i)     me_seen <= 1'b1;
        end
    end

    // Enemy hit / explosion animation sequencer
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            en_st     <= EN_IDLE;
            fcnt      <= '0;
            step      <= '0;
            explode   <= 1'b0;
            enemy_hit <= 1'b0;
        end else begin
            enemy_hit <= 1'b0;
            if (start) begin
                en_st   <= EN_IDLE;
                fcnt    <= '0;
                step    <= '0;
                explode <= 1'b0;
            end else if (eval) begin
                unique case (en_st)
                    EN_IDLE: begin
                        if (hit_eb) begin
                            enemy_hit <= 1'b1;
                            en_st     <= EN_EXPLODE;
                            fcnt      <= '0;
                            step      <= '0;
                            explode   <= 1'b1;
                        end
                    end
                    EN_EXPLODE: begin
                        if (fcnt == FRM_LAST) begin
                            fcnt <= '0;
                            if (step == STEP_LAST) begin
                                en_st   <= EN_IDLE;
                                step    <= '0;
                                explode <= 1'b0;
                            end else begin
                                step <= step + 1'b1;
                            end
                        end else begin
                            fcnt <= fcnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Player lives, invulnerability window and game-over request
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            pl_st    <= PL_ALIVE;
            lives    <= LIVES_RST;
            icnt     <= '0;
            invuln   <= 1'b0;
            gameover <= 1'b0;
            me_hit   <= 1'b0;
        end else begin
            me_hit <= 1'b0;
            if (start) begin
                pl_st    <= PL_ALIVE;
                lives    <= LIVES_RST;
                icnt     <= '0;
                invuln   <= 1'b0;
                gameover <= 1'b0;
            end else if (eval) begin
                unique case (pl_st)
                    PL_ALIVE: begin
                        if (hit_me) begin
                            me_hit <= 1'b1;
                            lives  <= lives - 1'b1;
                            if (lives == 2'd1) begin
                                pl_st    <= PL_DEAD;
                                gameover <= 1'b1;
                            end else begin
                                pl_st  <= PL_INVULN;
                                icnt   <= '0;
                                invuln <= 1'b1;
                            end
                        end
                    end
                    PL_INVULN: begin
                        if (icnt == INV_LAST) begin
                            pl_st  <= PL_ALIVE;
                            invuln <= 1'b0;
                        end else begin
                            icnt <= icnt + 1'b1;
                        end
                    end
                    PL_DEAD: begin
                        pl_st <= PL_DEAD;
                    end
                    default: begin
                        pl_st <= PL_ALIVE;
                    end
                endcase
            end
        end
    end

    bcd_counter4 u_score (
        .clk_vga (clk_vga),
        .rst_n   (rst_n),
        .clr     (start),
        .inc     (score_inc),
        .count   (bus.score_o)
    );

    assign bus.enemy_hit_o    = enemy_hit;
    assign bus.me_hit_o       = me_hit;
    assign bus.explode_o      = explode;
    assign bus.explode_step_o = step;
    assign bus.invuln_o       = invuln;
    assign bus.lives_o        = lives;
    assign bus.gameover_req_o = gameover;

endmodule

// File: tb/tb_crash_event_ctrl.sv
// Drives two controller instances (default and minimal parameters)
// with random crash frames against a frame-level reference model.
module tb_crash_event_ctrl;
    import crash_event_ctrl_pkg::*;

    logic clk_vga;
    logic rst_n;

    crash_event_ctrl_if bus0 ();
    crash_event_ctrl_if bus1 ();

    assign bus1.game_status_i        = bus0.game_status_i;
    assign bus1.frame_end_i          = bus0.frame_end_i;
    assign bus1.crash_enemy_bullet_i = bus0.crash_enemy_bullet_i;
    assign bus1.crash_me_enemy_i     = bus0.crash_me_enemy_i;

    crash_event_ctrl u_dut0 (
        .clk_vga (clk_vga),
        .rst_n   (rst_n),
        .bus     (bus0)
    );

    crash_event_ctrl #(
        .LIVES_INIT      (2),
        .EXPLODE_STEPS   (1),
        .FRAMES_PER_STEP (1),
        .INVULN_FRAMES   (3)
    ) u_dut1 (
        .clk_vga (clk_vga),
        .rst_n   (rst_n),
        .bus     (bus1)
    );

    initial clk_vga = 1'b0;
    always #5 clk_vga = ~clk_vga;

    int P_LIVES [2] = '{3, 2};
    int P_STEPS [2] = '{4, 1};
    int P_FPS   [2] = '{4, 1};
    int P_INV   [2] = '{60, 3};

    int m_score [2];
    int m_lives [2];
    int m_exp   [2];
    int m_inv   [2];
    bit m_dead  [2];
    bit m_ehit  [2];
    bit m_mhit  [2];

    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'((v / 1000) % 10);
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        return {d3, d2, d1, d0};
    endfunction

    task automatic chk(input int k, input string tag,
                       input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL u%0d.%s: got %h expected %h", k, tag, obs, exp);
        end
    endtask

    task automatic chk_inst(input int k, input logic eh, input logic mh,
                            input logic ex, input logic [1:0] st,
                            input logic iv, input logic [15:0] sc,
                            input logic [1:0] lv, input logic go);
        int total;
        int es;
        total = P_STEPS[k] * P_FPS[k];
        es = (m_exp[k] > 0) ? (total - m_exp[k]) / P_FPS[k] : 0;
        chk(k, "enemy_hit", 16'(eh), 16'(m_ehit[k]));
        chk(k, "me_hit", 16'(mh), 16'(m_mhit[k]));
        chk(k, "explode", 16'(ex), 16'(m_exp[k] > 0));
        chk(k, "explode_step", 16'(st), 16'(es));
        chk(k, "invuln", 16'(iv), 16'(m_inv[k] > 0));
        chk(k, "score", sc, to_bcd(m_score[k]));
        chk(k, "lives", 16'(lv), 16'(m_lives[k]));
        chk(k, "gameover", 16'(go), 16'(m_dead[k]));
    endtask

    task automatic check_all();
        chk_inst(0, bus0.enemy_hit_o, bus0.me_hit_o, bus0.explode_o,
                 bus0.explode_step_o, bus0.invuln_o, bus0.score_o,
                 bus0.lives_o, bus0.gameover_req_o);
        chk_inst(1, bus1.enemy_hit_o, bus1.me_hit_o, bus1.explode_o,
                 bus1.explode_step_o, bus1.invuln_o, bus1.score_o,
                 bus1.lives_o, bus1.gameover_req_o);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_score[k] = 0;
            m_lives[k] = P_LIVES[k];
            m_exp[k]   = 0;
            m_inv[k]   = 0;
            m_dead[k]  = 1'b0;
            m_ehit[k]  = 1'b0;
            m_mhit[k]  = 1'b0;
        end
    endtask

    task automatic model_frame(input bit eb, input bit me);
        for (int k = 0; k < 2; k++) begin
            if (m_exp[k] > 0) begin
                m_exp[k]--;
            end else if (eb) begin
                m_ehit[k]  = 1'b1;
                m_score[k] = (m_score[k] < 9999) ? m_score[k] + 1 : 9999;
                m_exp[k]   = P_STEPS[k] * P_FPS[k];
            end
            if (m_dead[k]) begin
                m_dead[k] = 1'b1;
            end else if (m_inv[k] > 0) begin
                m_inv[k]--;
            end else if (me) begin
                m_mhit[k] = 1'b1;
                m_lives[k]--;
                if (m_lives[k] == 0) m_dead[k] = 1'b1;
                else                 m_inv[k]  = P_INV[k];
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk_vga);
        #1;
    endtask

    task automatic frame(input int len, input int eb_pct, input int me_pct);
        bit eb;
        bit me;
        bit c_eb;
        bit c_me;
        bit running;
        eb = 1'b0;
        me = 1'b0;
        running = bus0.game_status_i == ST_RUN;
        for (int k = 0; k < 2; k++) begin
            m_ehit[k] = 1'b0;
            m_mhit[k] = 1'b0;
        end
        for (int i = 0; i < len; i++) begin
            c_eb = int'($urandom_range(0, 99)) < eb_pct;
            c_me = int'($urandom_range(0, 99)) < me_pct;
            bus0.crash_enemy_bullet_i = c_eb;
            bus0.crash_me_enemy_i     = c_me;
            bus0.frame_end_i          = (i == len - 1);
            eb |= c_eb;
            me |= c_me;
            cyc();
            if (i != len - 1) check_all();
        end
        bus0.frame_end_i          = 1'b0;
        bus0.crash_enemy_bullet_i = 1'b0;
        bus0.crash_me_enemy_i     = 1'b0;
        if (running) model_frame(eb, me);
        check_all();
    endtask

    task automatic start_game();
        bus0.game_status_i = ST_PRERUN;
        cyc();
        bus0.game_status_i = ST_RUN;
        cyc();
        model_reset();
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.game_status_i        = ST_PAUSE;
        bus0.frame_end_i          = 1'b0;
        bus0.crash_enemy_bullet_i = 1'b0;
        bus0.crash_me_enemy_i     = 1'b0;
        model_reset();
        repeat (3) cyc();
        check_all();
        rst_n = 1'b1;
        cyc();
        check_all();

        start_game();

        // one long-burst hit, then the full explosion window
        frame(50, 100, 0);
        for (int f = 1; f <= 16; f++) begin
            frame(8, (f >= 2 && f <= 10) ? 60 : 0, 0);
        end
        frame(8, 0, 0);

        // three player hits spaced beyond the invulnerability window
        for (int h = 0; h < 3; h++) begin
            frame(4, 0, 100);
            for (int f = 1; f <= 70; f++) begin
                frame(4, ($urandom_range(0, 1) != 0) ? 20 : 0,
                      (f == 10) ? 100 : 0);
            end
        end
        frame(4, 0, 100);

        // restart, then hammer enemy hits through BCD carries and saturation
        start_game();
        for (int f = 0; f < 20100; f++) begin
            frame(1, 100, 0);
        end

        // paused and over: nothing moves
        bus0.game_status_i = ST_PAUSE;
        for (int f = 0; f < 5; f++) frame(6, 100, 100);
        bus0.game_status_i = ST_OVER;
        for (int f = 0; f < 3; f++) frame(6, 100, 100);
        bus0.game_status_i = ST_RUN;
        for (int f = 0; f < 3; f++) frame(4, 50, 0);

        // async reset in the middle of an explosion
        start_game();
        frame(3, 100, 0);
        frame(3, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        cyc();
        check_all();
        rst_n = 1'b1;
        cyc();
        check_all();
        frame(5, 30, 100);
        frame(5, 100, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
